// File: rtl/sprite_car_engine.sv
// Player car sprite: road-local horizontal motion, registered pixel colour,
// obstacle collision with a blinking crash/respawn cycle.
module sprite_car_engine #(
    parameter int SPRITE_W     = 16,
    parameter int SPRITE_H     = 32,
    parameter int STEP         = 2,
    parameter int START_X      = 120,
    parameter int START_Y      = 400,
    parameter int CRASH_FRAMES = 60,
    parameter int BLINK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       obstacle_on,
    output logic [2:0] rgb,
    output logic       on,
    output logic [7:0] car_x,
    output logic       crashed,
    output logic [7:0] crash_count
);
    localparam int          BLINK_BIT = $clog2(BLINK_FRAMES);
    localparam logic [7:0]  MAX_X     = 8'(256 - SPRITE_W);
    localparam logic [8:0]  STEP_W    = 9'(STEP);
    localparam logic [10:0] SW        = 11'(SPRITE_W);
    localparam logic [10:0] Y0        = 11'(START_Y);
    localparam logic [10:0] Y1        = 11'(START_Y + SPRITE_H);
    localparam logic [7:0]  WH0       = 8'(3 * SPRITE_W / 8);
    localparam logic [7:0]  WH1       = 8'(5 * SPRITE_W / 8);
    localparam logic [7:0]  YL        = 8'(SPRITE_W / 4);
    localparam logic [7:0]  YR        = 8'(3 * SPRITE_W / 4);

    typedef enum logic {RUN, CRASH} state_t;

    state_t     state;
    logic [7:0] crash_cnt;
    logic       hit_pending;

    logic [7:0]  lx;
    logic        on_road;
    logic [10:0] lx_w, cx_w, y_w;
    logic        hit_area;
    logic        visible;
    logic        new_hit;
    logic [7:0]  px;
    logic [9:0]  py;
    logic [2:0]  colour;
    logic [8:0]  right_x;
    logic [7:0]  next_x;

    assign lx      = pixel_x[7:0];
    assign on_road = (pixel_x[9:8] == 2'b01);
    assign lx_w    = {3'b000, lx};
    assign cx_w    = {3'b000, car_x};
    assign y_w     = {1'b0, pixel_y};

    // Bounds kept at 11 bits so car_x + SPRITE_W cannot wrap at the road edge.
    assign hit_area = on_road && (lx_w >= cx_w) && (lx_w < cx_w + SW) &&
                      (y_w >= Y0) && (y_w < Y1);

    assign visible = (state == RUN) ? 1'b1 : ~crash_cnt[BLINK_BIT];
    assign new_hit = (state == RUN) && hit_area && obstacle_on;

    assign px = lx - car_x;
    assign py = pixel_y - 10'(START_Y);

    always_comb begin
        colour = 3'b100;
        if (px == WH0 || px == WH0 + 8'd1 || px == WH1 || px == WH1 + 8'd1)
            colour = 3'b111;
        else if ((px < YL || px >= YR) && py < 10'd4)
            colour = 3'b110;
    end

    assign right_x = {1'b0, car_x} + STEP_W;

    always_comb begin
        next_x = car_x;
        if (move_right && !move_left)
            next_x = (right_x > {1'b0, MAX_X}) ? MAX_X : right_x[7:0];
        else if (move_left && !move_right)
            next_x = ({1'b0, car_x} < STEP_W) ? 8'd0 : car_x - STEP_W[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            car_x       <= 8'(START_X);
            crash_cnt   <= 8'd0;
            hit_pending <= 1'b0;
            crash_count <= 8'd0;
            on          <= 1'b0;
            rgb         <= 3'b000;
            crashed     <= 1'b0;
        end else begin
            on  <= hit_area && visible;
            rgb <= (hit_area && visible) ? colour : 3'b000;

            case (state)
                RUN: begin
                    if (frame_tick) begin
                        // A hit seen on the consuming tick survives for the next one.
                        hit_pending <= new_hit;
                        if (hit_pending) begin
                            state     <= CRASH;
                            crashed   <= 1'b1;
                            crash_cnt <= 8'(CRASH_FRAMES - 1);
                            if (crash_count != 8'hFF)
                                crash_count <= crash_count + 8'd1;
                        end else begin
                            car_x <= next_x;
                        end
                    end else if (new_hit) begin
                        hit_pending <= 1'b1;
                    end
                end
                CRASH: begin
                    if (frame_tick) begin
                        if (crash_cnt == 8'd0) begin
                            state       <= RUN;
                            crashed     <= 1'b0;
                            car_x       <= 8'(START_X);
                            hit_pending <= 1'b0;
                        end else begin
                            crash_cnt <= crash_cnt - 8'd1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_car_engine.sv
// Directed bench for sprite_car_engine with hand-computed expectations.
module tb_sprite_car_engine;
    logic       clk = 1'b0;
    logic       reset, frame_tick, move_left, move_right, obstacle_on;
    logic [9:0] pixel_x, pixel_y;
    logic [2:0] rgb;
    logic       on, crashed;
    logic [7:0] car_x, crash_count;

    int checks = 0;
    int failures = 0;

    sprite_car_engine dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .move_left(move_left), .move_right(move_right),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .obstacle_on(obstacle_on),
        .rgb(rgb), .on(on), .car_x(car_x), .crashed(crashed),
        .crash_count(crash_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    int exp_x;

    initial begin
        reset = 0; frame_tick = 0; move_left = 0; move_right = 0;
        obstacle_on = 0; pixel_x = 0; pixel_y = 0;
        step();
        do_reset();
        chk("rst_on", on, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_car_x", car_x, 120);
        chk("rst_crashed", crashed, 0);
        chk("rst_count", crash_count, 0);

        // Pixel colour and bounds at car_x=120 (road column 376 = lx 120)
        pix(376, 400); chk("px_tl_on", on, 1); chk("px_tl_rgb", rgb, 3'b110);
        pix(392, 400); chk("px_right_on", on, 0); chk("px_right_rgb", rgb, 0);
        pix(382, 410); chk("px_white", rgb, 3'b111);
        pix(376, 410); chk("px_red", rgb, 3'b100);
        pix(391, 431); chk("px_br_on", on, 1); chk("px_br_rgb", rgb, 3'b100);
        pix(376, 432); chk("px_bottom_on", on, 0);
        pix(120, 400); chk("px_offroad_on", on, 0);
        pix(375, 400); chk("px_left_on", on, 0);
        pixel_x = 0; pixel_y = 0;

        // Right to the clamp, then left to zero
        exp_x = 120;
        move_right = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            exp_x = (exp_x + 2 > 240) ? 240 : exp_x + 2;
            chk("mv_right", car_x, exp_x);
        end
        move_right = 0; move_left = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            exp_x = (exp_x - 2 < 0) ? 0 : exp_x - 2;
            chk("mv_left", car_x, exp_x);
        end
        move_left = 0; move_right = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("mv_to_10", car_x, 10);
        move_left = 1;
        tick();
        chk("mv_both", car_x, 10);
        move_left = 0;
        for (int i = 0; i < 5; i++) step();
        chk("mv_no_tick", car_x, 10);
        move_right = 0;

        // Crash sequence from a fresh reset
        do_reset();
        pixel_x = 10'd376; pixel_y = 10'd400; obstacle_on = 1;
        step();
        obstacle_on = 0; pixel_x = 0; pixel_y = 0;
        chk("pre_crash", crashed, 0);
        move_right = 1;
        tick();
        move_right = 0;
        chk("crash_enter", crashed, 1);
        chk("crash_count1", crash_count, 1);
        chk("crash_no_move", car_x, 120);
        for (int k = 0; k < 59; k++) begin
            pixel_x = 10'd380; pixel_y = 10'd405; obstacle_on = 1; move_left = 1;
            step();
            chk("blink_on", on, (((59 - k) >> 3) & 1) == 0);
            obstacle_on = 0;
            tick();
        end
        move_left = 0;
        chk("crash_last", crashed, 1);
        tick();
        chk("respawn_crashed", crashed, 0);
        chk("respawn_x", car_x, 120);
        for (int i = 0; i < 3; i++) tick();
        chk("no_recrash", crashed, 0);
        chk("no_recrash_cnt", crash_count, 1);

        // Hit captured on a tick cycle crashes on the following tick
        pixel_x = 10'd376; pixel_y = 10'd400; obstacle_on = 1;
        tick();
        obstacle_on = 0; pixel_x = 0; pixel_y = 0;
        chk("tick_hit_wait", crashed, 0);
        tick();
        chk("tick_hit_crash", crashed, 1);
        chk("crash_count2", crash_count, 2);

        // Reset mid-crash beats frame_tick
        reset = 1; frame_tick = 1;
        step();
        reset = 0; frame_tick = 0;
        chk("midrst_crashed", crashed, 0);
        chk("midrst_x", car_x, 120);
        chk("midrst_cnt", crash_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
